// File: rtl/riscv_dmem_sync_ram.sv
// Single-port synchronous data memory for the RISC-V load/store path.
// Synchronous write, registered read (latency 1), no write-through.
module riscv_dmem_sync_ram #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  logic rd_en;
  logic wr_en;

  assign rd_en = en & ~we;
  assign wr_en = en & we;

  // Array has no reset so it maps onto a RAM macro; rst_n only gates the write.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_riscv_dmem_sync_ram.sv
// Bench for riscv_dmem_sync_ram: directed vector table, reset sequences and
// randomized traffic checked against an array-based memory model.
module tb_riscv_dmem_sync_ram;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 2**AW;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  int checks;
  int errors;

  // Reference model: word store with written flags and the expected read register.
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_valid [DEPTH];
  logic [DW-1:0] m_rdata;
  bit            m_known;

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
    string         name;
  } vec_t;

  vec_t tab [16];

  riscv_dmem_sync_ram #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rdata=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one access, advance past the next rising edge, update the model.
  task automatic cycle(input logic e, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    en = e;
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_rdata = '0;
      m_known = 1'b1;
    end else if (e && w) begin
      m_mem[a]   = d;
      m_valid[a] = 1'b1;
    end else if (e) begin
      m_known = m_valid[a];
      m_rdata = m_mem[a];
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_rdata = '0;
    m_known = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_mem[i]   = '0;
    end

    tab[0]  = '{1'b1, 1'b1, 7'd3,   32'hDEADBEEF, 32'h00000000, "write3_no_wt"};
    tab[1]  = '{1'b1, 1'b0, 7'd3,   32'h0,        32'hDEADBEEF, "read3"};
    tab[2]  = '{1'b0, 1'b0, 7'd5,   32'h0,        32'hDEADBEEF, "hold1"};
    tab[3]  = '{1'b0, 1'b1, 7'd5,   32'hFFFFFFFF, 32'hDEADBEEF, "hold2_we"};
    tab[4]  = '{1'b0, 1'b0, 7'd5,   32'h0,        32'hDEADBEEF, "hold3"};
    tab[5]  = '{1'b1, 1'b1, 7'd7,   32'h12345678, 32'hDEADBEEF, "write7_no_wt"};
    tab[6]  = '{1'b1, 1'b0, 7'd7,   32'h0,        32'h12345678, "read7"};
    tab[7]  = '{1'b1, 1'b0, 7'd3,   32'h0,        32'hDEADBEEF, "reread3"};
    tab[8]  = '{1'b0, 1'b1, 7'd7,   32'hFFFFFFFF, 32'hDEADBEEF, "idle_write7"};
    tab[9]  = '{1'b1, 1'b0, 7'd7,   32'h0,        32'h12345678, "read7_after_idle"};
    tab[10] = '{1'b1, 1'b1, 7'd0,   32'hA5A5A5A5, 32'h12345678, "write0"};
    tab[11] = '{1'b1, 1'b1, 7'd127, 32'h5A5A5A5A, 32'h12345678, "write127"};
    tab[12] = '{1'b1, 1'b0, 7'd0,   32'h0,        32'hA5A5A5A5, "read0"};
    tab[13] = '{1'b1, 1'b0, 7'd127, 32'h0,        32'h5A5A5A5A, "read127"};
    tab[14] = '{1'b1, 1'b0, 7'd3,   32'h0,        32'hDEADBEEF, "read3_final"};
    tab[15] = '{1'b0, 1'b0, 7'd0,   32'h0,        32'hDEADBEEF, "idle_final"};

    // Reset with a read requested: rdata cleared before any clock edge.
    rst_n = 1'b0;
    en = 1'b1;
    we = 1'b0;
    addr = 7'd3;
    wdata = '0;
    #1;
    check("reset_async_start", rdata, '0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_during_read", rdata, '0);
    end
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_idle", rdata, '0);
    cycle(1'b0, 1'b0, 7'd9, '0);
    check("release_idle2", rdata, '0);

    for (int unsigned i = 0; i < 16; i++) begin
      cycle(tab[i].en, tab[i].we, tab[i].addr, tab[i].wdata);
      check(tab[i].name, rdata, tab[i].exp);
    end

    // Asynchronous reset pulse between edges while rdata is nonzero.
    rst_n = 1'b0;
    #1;
    check("midop_reset_async", rdata, '0);
    #2;
    rst_n = 1'b1;
    #1;
    check("midop_reset_released", rdata, '0);
    m_rdata = '0;
    cycle(1'b0, 1'b0, 7'd3, '0);
    check("midop_idle_after", rdata, '0);
    cycle(1'b1, 1'b0, 7'd3, '0);
    check("midop_retained3", rdata, 32'hDEADBEEF);

    // Write on an edge that coincides with reset low must be dropped.
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 7'd3, 32'hBAD0BAD0);
    check("write_in_reset_rdata", rdata, '0);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 7'd3, '0);
    check("write_in_reset_dropped", rdata, 32'hDEADBEEF);

    // Read-after-write to the same address on consecutive edges.
    cycle(1'b1, 1'b1, 7'd64, 32'hCAFEF00D);
    cycle(1'b1, 1'b0, 7'd64, '0);
    check("raw_same_addr", rdata, 32'hCAFEF00D);

    // Random traffic, biased to a small address window for frequent hits.
    for (int unsigned n = 0; n < 3000; n++) begin
      logic          e;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      e = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                      : AW'($urandom_range(0, 15));
      d = $urandom;
      if ($urandom_range(0, 63) == 0) rst_n = 1'b0;
      cycle(e, w, a, d);
      rst_n = 1'b1;
      if (m_known) check("random", rdata, m_rdata);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
